// File: rtl/dp_ram_pipe.sv
// Simple dual-port register-array RAM: byte-lane writes, 1- or 2-cycle read latency,
// selectable read-during-write policy, out-of-range flags and a saturating collision counter.
module dp_ram_pipe #(
   parameter int ADDR_SIZE  = 4,
   parameter int DATA_SIZE  = 32,
   parameter int DEPTH      = 2**4,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr,
   input  logic [ADDR_SIZE-1:0]   addr_wr,
   input  logic [DATA_SIZE-1:0]   data_wr,
   input  logic [DATA_SIZE/8-1:0] be_wr,
   input  logic                   rd,
   input  logic [ADDR_SIZE-1:0]   addr_rd,
   output logic [DATA_SIZE-1:0]   data_rd,
   output logic                   rd_valid,
   output logic                   rd_oob,
   output logic                   wr_oob,
   output logic [15:0]            coll_cnt
);

   localparam int NB = DATA_SIZE / 8;
   localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE+1)'(DEPTH);

   function automatic logic [DATA_SIZE-1:0] merge_bytes(input logic [DATA_SIZE-1:0] old_w,
                                                        input logic [DATA_SIZE-1:0] new_w,
                                                        input logic [NB-1:0]        be);
      logic [DATA_SIZE-1:0] res;
      res = old_w;
      for (int i = 0; i < NB; i++)
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      return res;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [DATA_SIZE-1:0] mem_q [DEPTH];
   logic                 wr_in_rng, rd_in_rng, coll;
   logic [DATA_SIZE-1:0] wr_merged, rd_word;
   logic [15:0]          coll_cnt_q, coll_cnt_d;
   logic                 wr_oob_q;
   logic                 vld_p0_q, oob_p0_q;
   logic [DATA_SIZE-1:0] data_p0_q;

   always_comb begin
      wr_in_rng  = {1'b0, addr_wr} < DEPTH_L;
      rd_in_rng  = {1'b0, addr_rd} < DEPTH_L;
      coll       = wr && rd && (addr_wr == addr_rd) && rd_in_rng && (be_wr != '0);
      wr_merged  = merge_bytes(mem_q[addr_wr], data_wr, be_wr);
      // On a collision the write-first policy forwards the merged word straight to the read port.
      if (!rd_in_rng)
         rd_word = '0;
      else if (RDW_MODE == 1 && coll)
         rd_word = wr_merged;
      else
         rd_word = mem_q[addr_rd];
      coll_cnt_d = coll ? sat_inc(coll_cnt_q) : coll_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr && wr_in_rng) begin
         mem_q[addr_wr] <= wr_merged;
      end
   end

   // Stage p0: word captured at the sampling edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0_q   <= 1'b0;
         oob_p0_q   <= 1'b0;
         data_p0_q  <= '0;
         wr_oob_q   <= 1'b0;
         coll_cnt_q <= '0;
      end else begin
         vld_p0_q   <= rd;
         oob_p0_q   <= rd && !rd_in_rng;
         if (rd) data_p0_q <= rd_word;
         wr_oob_q   <= wr && !wr_in_rng;
         coll_cnt_q <= coll_cnt_d;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                 vld_p1_q, oob_p1_q;
         logic [DATA_SIZE-1:0] data_p1_q;
         // Stage p1: extra output register
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_p1_q  <= 1'b0;
               oob_p1_q  <= 1'b0;
               data_p1_q <= '0;
            end else begin
               vld_p1_q <= vld_p0_q;
               oob_p1_q <= oob_p0_q;
               if (vld_p0_q) data_p1_q <= data_p0_q;
            end
         end
         assign rd_valid = vld_p1_q;
         assign rd_oob   = oob_p1_q;
         assign data_rd  = data_p1_q;
      end else begin : g_lat1
         assign rd_valid = vld_p0_q;
         assign rd_oob   = oob_p0_q;
         assign data_rd  = data_p0_q;
      end
   endgenerate

   assign wr_oob   = wr_oob_q;
   assign coll_cnt = coll_cnt_q;

endmodule
